acq_sequencer: RTL and testbench
================================

# acq_sequencer

Sequences one ADC acquisition per trigger pulse: it drives the converter's CNV strobe, waits out the conversion time, hands a transfer-start request to the SPI engine and waits for its completion. It counts completed samples against a programmed total and flags triggers that arrive while an acquisition is still in flight. It sits between the periodic trigger generator and the SPI engine in the SPI acquisition path.

## Interface
- CNT_WIDTH, 32, width of sample total and sample counter
- WAIT_WIDTH, 16, width of conversion-wait setting
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- enable  in  1  arms sequencer; low clears counters and sticky flags once idle
- num_samples  in  CNT_WIDTH  samples per run; 0 = continuous
- cnv_high  in  8  CNV pulse width in cycles; 0 treated as 1
- conv_wait  in  WAIT_WIDTH  cycles between CNV fall and SPI start request; 0 = none
- trigger  in  1  single-cycle acquisition request
- cnv  out  1  converter start strobe
- spi_start_valid  out  1  transfer request to SPI engine
- spi_start_ready  in  1  SPI engine accepts request
- spi_done  in  1  single-cycle pulse, transfer complete
- busy  out  1  high in any state except IDLE and STOPPED
- done  out  1  single-cycle pulse when num_samples reached
- sample_count  out  CNT_WIDTH  completed samples this run
- overrun  out  1  sticky, trigger received while not IDLE

## Operation
- States: IDLE, CNV, WAIT, START, XFER, STOPPED.
- IDLE: trigger && enable -> CNV; cnv_high, conv_wait, num_samples latched at this point. trigger with enable low ignored, no overrun.
- CNV: cnv=1; after max(cnv_high,1) cycles -> WAIT (conv_wait>0) or START.
- WAIT: count conv_wait cycles -> START.
- START: spi_start_valid=1 held until spi_start_ready sampled high; valid drops next cycle -> XFER.
- XFER: on spi_done, sample_count increments; if latched num_samples≠0 and new count == num_samples -> STOPPED with done pulse, else -> IDLE.
- STOPPED: triggers ignored without overrun; enable low -> IDLE.
- trigger in any of CNV/WAIT/START/XFER: ignored, overrun set. Trigger on the cycle of spi_done also counts as overrun.
- enable falling mid-acquisition: current acquisition completes (no SPI abort); returns to IDLE (not STOPPED, no done).
- In IDLE with enable low: sample_count and overrun cleared to 0.
- sample_count saturates at all-ones in continuous mode (no wrap).
- spi_done outside XFER ignored.

## Timing
- Reset: state IDLE; cnv, spi_start_valid, busy, done, overrun = 0; sample_count = 0.
- All outputs registered.
- trigger at cycle t (IDLE) -> cnv high t+1 .. t+cnv_high'; busy high from t+1.
- spi_start_valid first high at t+1+cnv_high'+conv_wait (cnv_high' = max(cnv_high,1)).
- spi_done at cycle d -> sample_count updated and done pulse at d+1; busy low at d+1 when entering IDLE or STOPPED.
- Minimum trigger-to-trigger period without overrun: cnv_high'+conv_wait+SPI handshake+transfer+1.

## Configuration
- ACQ_OVERRUN_COUNT_EN defined: adds output overrun_count (out, 16) counting rejected triggers, saturating at 0xFFFF, reset to 0 and cleared with overrun.
- Not defined: port absent, only the sticky overrun flag exists.

## Test plan
- enable=1, cnv_high=3, conv_wait=5, trigger at cycle 10, ready tied high -> cnv high cycles 11-13, spi_start_valid single cycle at 19, sample_count=1 cycle after spi_done.
- num_samples=4, triggers every 100 cycles -> done pulses once after 4th spi_done, state STOPPED, 5th trigger ignored, overrun=0.
- Trigger during WAIT and on spi_done cycle -> overrun=1, sample_count unaffected; with ACQ_OVERRUN_COUNT_EN overrun_count=2.
- spi_start_ready held low 20 cycles -> spi_start_valid held steady 20+ cycles, drops one cycle after ready.
- cnv_high=0, conv_wait=0 -> cnv high exactly 1 cycle, valid asserted next cycle.
- resetn low during XFER -> all outputs 0 immediately; subsequent spi_done ignored, next trigger starts new acquisition.

Source files
------------

// File: rtl/acq_sequencer.sv
// ADC acquisition sequencer: CNV strobe, conversion wait, SPI start handshake, sample counting.
// Optional ACQ_OVERRUN_COUNT_EN adds a saturating 16-bit count of rejected triggers.
module acq_sequencer #(
  parameter int CNT_WIDTH  = 32,
  parameter int WAIT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic [CNT_WIDTH-1:0]  num_samples,
  input  logic [7:0]            cnv_high,
  input  logic [WAIT_WIDTH-1:0] conv_wait,
  input  logic                  trigger,
  output logic                  cnv,
  output logic                  spi_start_valid,
  input  logic                  spi_start_ready,
  input  logic                  spi_done,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  sample_count,
`ifdef ACQ_OVERRUN_COUNT_EN
  output logic [15:0]           overrun_count,
`endif
  output logic                  overrun
);

  // state   | meaning
  // IDLE    | waiting for trigger; clears counters while enable is low
  // CNV     | converter strobe high for max(cnv_high,1) cycles
  // WAIT    | conversion time countdown
  // START   | SPI start request pending handshake
  // XFER    | SPI transfer in progress, waiting for spi_done
  // STOPPED | programmed sample total reached; waits for enable low
  typedef enum logic [2:0] {
    S_IDLE, S_CNV, S_WAIT, S_START, S_XFER, S_STOPPED
  } state_t;

  localparam int TW = (WAIT_WIDTH > 8) ? WAIT_WIDTH : 8;

  state_t                state;
  logic [TW-1:0]         timer;
  logic [WAIT_WIDTH-1:0] wait_lat;
  logic [CNT_WIDTH-1:0]  num_lat;
  logic [TW-1:0]         cnv_load;
  logic [CNT_WIDTH-1:0]  count_inc;
  logic                  in_flight;

  always_comb begin
    cnv_load  = (cnv_high == 8'd0) ? '0 : TW'(cnv_high - 8'd1);
    count_inc = (&sample_count) ? sample_count : sample_count + CNT_WIDTH'(1);
    in_flight = (state == S_CNV) || (state == S_WAIT) ||
                (state == S_START) || (state == S_XFER);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= S_IDLE;
      timer           <= '0;
      wait_lat        <= '0;
      num_lat         <= '0;
      cnv             <= 1'b0;
      spi_start_valid <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      sample_count    <= '0;
      overrun         <= 1'b0;
`ifdef ACQ_OVERRUN_COUNT_EN
      overrun_count   <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (trigger && in_flight) begin
        overrun <= 1'b1;
`ifdef ACQ_OVERRUN_COUNT_EN
        if (overrun_count != 16'hFFFF) overrun_count <= overrun_count + 16'd1;
`endif
      end
      case (state)
        S_IDLE: begin
          if (!enable) begin
            sample_count  <= '0;
            overrun       <= 1'b0;
`ifdef ACQ_OVERRUN_COUNT_EN
            overrun_count <= '0;
`endif
          end else if (trigger) begin
            state    <= S_CNV;
            cnv      <= 1'b1;
            busy     <= 1'b1;
            timer    <= cnv_load;
            wait_lat <= conv_wait;
            num_lat  <= num_samples;
          end
        end
        S_CNV: begin
          if (timer == '0) begin
            cnv <= 1'b0;
            if (wait_lat != '0) begin
              state <= S_WAIT;
              timer <= TW'(wait_lat - WAIT_WIDTH'(1));
            end else begin
              state           <= S_START;
              spi_start_valid <= 1'b1;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_WAIT: begin
          if (timer == '0) begin
            state           <= S_START;
            spi_start_valid <= 1'b1;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_START: begin
          if (spi_start_ready) begin
            state           <= S_XFER;
            spi_start_valid <= 1'b0;
          end
        end
        S_XFER: begin
          if (spi_done) begin
            sample_count <= count_inc;
            busy         <= 1'b0;
            // A run aborted by enable going low ends in IDLE without a done pulse
            if (enable && (num_lat != '0) && (count_inc == num_lat)) begin
              state <= S_STOPPED;
              done  <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_STOPPED: begin
          if (!enable) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acq_sequencer.sv
// Scoreboard bench for acq_sequencer: expected CNV, start-request and sample-count events
// are queued when triggers/spi_done are driven and matched as the DUT produces them.
module tb_acq_sequencer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] num_samples = '0;
  logic [7:0]  cnv_high = '0;
  logic [15:0] conv_wait = '0;
  logic        trigger = 1'b0;
  logic        spi_start_ready = 1'b0;
  logic        spi_done = 1'b0;
  logic        cnv, spi_start_valid, busy, done, overrun;
  logic [31:0] sample_count;
`ifdef ACQ_OVERRUN_COUNT_EN
  logic [15:0] overrun_count;
`endif

  acq_sequencer #(.CNT_WIDTH(32), .WAIT_WIDTH(16)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .num_samples(num_samples),
    .cnv_high(cnv_high), .conv_wait(conv_wait), .trigger(trigger), .cnv(cnv),
    .spi_start_valid(spi_start_valid), .spi_start_ready(spi_start_ready),
    .spi_done(spi_done), .busy(busy), .done(done), .sample_count(sample_count),
`ifdef ACQ_OVERRUN_COUNT_EN
    .overrun_count(overrun_count),
`endif
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cyc; int val;} ev_t;
  ev_t q_cnv[$];
  ev_t q_val[$];
  ev_t q_cnt[$];

  int checks = 0;
  int errors = 0;
  logic [31:0] m_count = '0;
  logic [31:0] m_num = '0;
  logic        m_ovr = 1'b0;
  int          m_ovc = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: pops expected events as the DUT produces them
  logic        prev_cnv = 1'b0, prev_val = 1'b0;
  logic [31:0] prev_cnt = '0;
  int          rise_cyc = 0, exp_w = 0;
  always @(negedge clk) begin
    ev_t ev;
    if (cnv && !prev_cnv) begin
      check_eq("cnv_pending", q_cnv.size() > 0, 1);
      if (q_cnv.size() > 0) begin
        ev = q_cnv.pop_front();
        check_eq("cnv_rise_cycle", cyc, ev.cyc);
        exp_w = ev.val;
        rise_cyc = cyc;
      end
    end
    if (!cnv && prev_cnv) check_eq("cnv_width", cyc - rise_cyc, exp_w);
    if (spi_start_valid && !prev_val) begin
      check_eq("valid_pending", q_val.size() > 0, 1);
      if (q_val.size() > 0) begin
        ev = q_val.pop_front();
        check_eq("valid_rise_cycle", cyc, ev.cyc);
      end
    end
    if (sample_count > prev_cnt) begin
      check_eq("count_pending", q_cnt.size() > 0, 1);
      if (q_cnt.size() > 0) begin
        ev = q_cnt.pop_front();
        check_eq("count_cycle", cyc, ev.cyc);
        check_eq("count_value", sample_count, ev.val);
      end
    end
    prev_cnv <= cnv;
    prev_val <= spi_start_valid;
    prev_cnt <= sample_count;
  end

  task automatic pulse_trigger();
    int w = (cnv_high == 8'd0) ? 1 : int'(cnv_high);
    q_cnv.push_back('{cyc + 1, w});
    q_val.push_back('{cyc + 1 + w + int'(conv_wait), 0});
    m_num = num_samples;
    trigger = 1'b1;
    step(1);
    trigger = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!spi_start_valid && n < 300) begin
      step(1);
      n++;
    end
    check_eq("valid_seen", spi_start_valid, 1);
  endtask

  task automatic run_acq(input int rdy_lat, input bit ovr_wait, input bit ovr_done);
    int   w = (cnv_high == 8'd0) ? 1 : int'(cnv_high);
    logic exp_done;
    pulse_trigger();
    if (ovr_wait) begin
      step(w);
      trigger = 1'b1;
      m_ovr = 1'b1;
      m_ovc++;
      step(1);
      trigger = 1'b0;
    end
    wait_valid();
    for (int i = 0; i < rdy_lat; i++) begin
      check_eq("valid_hold", spi_start_valid, 1);
      step(1);
    end
    spi_start_ready = 1'b1;
    step(1);
    spi_start_ready = 1'b0;
    check_eq("valid_drop", spi_start_valid, 0);
    step(4);
    check_eq("busy_xfer", busy, 1);
    spi_done = 1'b1;
    if (ovr_done) begin
      trigger = 1'b1;
      m_ovr = 1'b1;
      m_ovc++;
    end
    if (m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
    q_cnt.push_back('{cyc + 1, int'(m_count)});
    exp_done = enable && (m_num != 0) && (m_count == m_num);
    step(1);
    spi_done = 1'b0;
    trigger = 1'b0;
    check_eq("done_pulse", done, exp_done);
    check_eq("busy_after", busy, 0);
    check_eq("overrun", overrun, m_ovr);
`ifdef ACQ_OVERRUN_COUNT_EN
    check_eq("overrun_count", overrun_count, m_ovc);
`endif
    step(1);
    check_eq("done_single", done, 0);
  endtask

  task automatic disable_clear();
    enable = 1'b0;
    step(2);
    m_count = '0;
    m_ovr = 1'b0;
    m_ovc = 0;
    check_eq("clr_count", sample_count, 0);
    check_eq("clr_overrun", overrun, 0);
`ifdef ACQ_OVERRUN_COUNT_EN
    check_eq("clr_overrun_count", overrun_count, 0);
`endif
    enable = 1'b1;
    step(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    step(2);
    check_eq("rst_outs", {cnv, spi_start_valid, busy, done, overrun}, 0);
    check_eq("rst_count", sample_count, 0);
    resetn = 1'b1;
    enable = 1'b1;

    // basic timing: trigger at cycle 10, ready tied high
    cnv_high = 8'd3;
    conv_wait = 16'd5;
    num_samples = 32'd0;
    spi_start_ready = 1'b1;
    while (cyc < 10) step(1);
    run_acq(0, 1'b0, 1'b0);

    // programmed run of 4 samples, triggers 100 cycles apart
    disable_clear();
    num_samples = 32'd4;
    start = cyc;
    for (int k = 0; k < 4; k++) begin
      while (cyc < start + 100 * k) step(1);
      run_acq(0, 1'b0, 1'b0);
    end
    while (cyc < start + 400) step(1);
    trigger = 1'b1;
    step(1);
    trigger = 1'b0;
    step(10);
    check_eq("stopped_busy", busy, 0);
    check_eq("stopped_overrun", overrun, 0);
    check_eq("stopped_count", sample_count, 4);
    disable_clear();
    num_samples = 32'd0;

    // overrun: trigger during WAIT and on the spi_done cycle
    run_acq(0, 1'b1, 1'b1);
    disable_clear();

    // ready held low for 20 cycles
    cnv_high = 8'd2;
    conv_wait = 16'd3;
    run_acq(20, 1'b0, 1'b0);

    // degenerate timing settings
    cnv_high = 8'd0;
    conv_wait = 16'd0;
    run_acq(0, 1'b0, 1'b0);

    // reset during XFER
    cnv_high = 8'd1;
    conv_wait = 16'd2;
    pulse_trigger();
    wait_valid();
    spi_start_ready = 1'b1;
    step(1);
    spi_start_ready = 1'b0;
    step(2);
    check_eq("busy_pre_reset", busy, 1);
    resetn = 1'b0;
    #1;
    check_eq("async_rst_outs", {cnv, spi_start_valid, busy, done, overrun}, 0);
    check_eq("async_rst_count", sample_count, 0);
    m_count = '0;
    m_ovr = 1'b0;
    m_ovc = 0;
    step(2);
    resetn = 1'b1;
    step(2);
    spi_done = 1'b1;
    step(1);
    spi_done = 1'b0;
    step(1);
    check_eq("stray_done_count", sample_count, 0);
    check_eq("stray_done_busy", busy, 0);
    run_acq(0, 1'b0, 1'b0);

    step(5);
    check_eq("queues_drained", q_cnv.size() + q_val.size() + q_cnt.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
